// File: rtl/datamem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Grant statistics are compiled in when DATAMEM_ARB_STATS_EN is defined.
package datamem_arb_pkg;

    localparam int WORD_WIDTH_DEF = 32;
    localparam int MEM_DEPTH_DEF  = 1024;
    localparam int CNT_WIDTH_DEF  = 16;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } arb_state_e;

endpackage : datamem_arb_pkg

// File: rtl/datamem_arbiter_rr2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the
// requester that was not granted last.
module arb_rr2
    import datamem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] gnt_o
);

    // One-hot grant selection; bit 0 is the CPU, bit 1 the DMA master.
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11: begin
                if (last_grant_i == REQ_CPU) begin
                    gnt_o = 2'b10;
                end else begin
                    gnt_o = 2'b01;
                end
            end
            default: gnt_o = 2'b00;
        endcase
    end

endmodule : arb_rr2

// File: rtl/datamem_arbiter.sv
// CPU/DMA arbiter and sequencer for the big-endian data memory; one word per grant.
// Optional grant counters are enabled by defining DATAMEM_ARB_STATS_EN.
module datamem_arbiter
    import datamem_arb_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int MEM_DEPTH  = MEM_DEPTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [WORD_WIDTH-1:0] cpu_addr,
    input  logic [WORD_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic                  cpu_err,
    output logic [WORD_WIDTH-1:0] cpu_rdata,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [WORD_WIDTH-1:0] dma_addr,
    input  logic [WORD_WIDTH-1:0] dma_wdata,
    output logic                  dma_ack,
    output logic                  dma_err,
    output logic [WORD_WIDTH-1:0] dma_rdata,
    output logic [WORD_WIDTH-1:0] mem_addr,
    output logic                  mem_wr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    input  logic [WORD_WIDTH-1:0] mem_rdata,
    output logic [CNT_WIDTH-1:0]  cpu_grants,
    output logic [CNT_WIDTH-1:0]  dma_grants
);

    localparam logic [WORD_WIDTH-1:0] MAX_ADDR = WORD_WIDTH'(MEM_DEPTH - 4);

    arb_state_e            state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_grant_q, last_grant_d;
    logic [WORD_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;
    logic                  cpu_ack_q, cpu_ack_d;
    logic                  cpu_err_q, cpu_err_d;
    logic [WORD_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic                  dma_ack_q, dma_ack_d;
    logic                  dma_err_q, dma_err_d;
    logic [WORD_WIDTH-1:0] dma_rdata_q, dma_rdata_d;

    logic [1:0]            req_s;
    logic [1:0]            gnt_s;
    logic                  grant_s;
    logic                  grant_owner_s;
    logic [WORD_WIDTH-1:0] req_addr_s;
    logic [WORD_WIDTH-1:0] req_wdata_s;
    logic                  req_we_s;
    logic                  req_err_s;

    // Value captured into the owner's rdata at the end of the memory cycle:
    // zero on a rejected access, memory data on a read, unchanged on a write.
    function automatic logic [WORD_WIDTH-1:0] next_rdata(
        input logic                  err,
        input logic                  we,
        input logic [WORD_WIDTH-1:0] mem_data,
        input logic [WORD_WIDTH-1:0] old_data
    );
        logic [WORD_WIDTH-1:0] res;
        if (err) begin
            res = {WORD_WIDTH{1'b0}};
        end else if (!we) begin
            res = mem_data;
        end else begin
            res = old_data;
        end
        return res;
    endfunction

    assign req_s = {dma_req, cpu_req};

    arb_rr2 u_arb (
        .req_i        (req_s),
        .last_grant_i (last_grant_q),
        .gnt_o        (gnt_s)
    );

    // Mux the winning requester's fields and pre-check them; the compare is
    // unsigned over the full width so addresses near the top never wrap to legal.
    always_comb begin
        grant_s       = gnt_s[0] | gnt_s[1];
        grant_owner_s = REQ_CPU;
        req_addr_s    = cpu_addr;
        req_wdata_s   = cpu_wdata;
        req_we_s      = cpu_we;
        if (gnt_s[1]) begin
            grant_owner_s = REQ_DMA;
            req_addr_s    = dma_addr;
            req_wdata_s   = dma_wdata;
            req_we_s      = dma_we;
        end else begin
            grant_owner_s = REQ_CPU;
        end
        req_err_s = (req_addr_s[1:0] != 2'b00) | (req_addr_s > MAX_ADDR);
    end

    // Sequencer next-state: IDLE grants, BUSY drives memory, DONE shows the ack.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        err_d        = err_q;
        cpu_ack_d    = 1'b0;
        cpu_err_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        dma_ack_d    = 1'b0;
        dma_err_d    = 1'b0;
        dma_rdata_d  = dma_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_s) begin
                    owner_d      = grant_owner_s;
                    last_grant_d = grant_owner_s;
                    addr_d       = req_addr_s;
                    wdata_d      = req_wdata_s;
                    we_d         = req_we_s;
                    err_d        = req_err_s;
                    state_d      = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                state_d = DONE;
                if (owner_q == REQ_CPU) begin
                    cpu_ack_d   = 1'b1;
                    cpu_err_d   = err_q;
                    cpu_rdata_d = next_rdata(err_q, we_q, mem_rdata, cpu_rdata_q);
                end else begin
                    dma_ack_d   = 1'b1;
                    dma_err_d   = err_q;
                    dma_rdata_d = next_rdata(err_q, we_q, mem_rdata, dma_rdata_q);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer and response registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= IDLE;
            owner_q      <= REQ_CPU;
            last_grant_q <= REQ_DMA;
            addr_q       <= {WORD_WIDTH{1'b0}};
            wdata_q      <= {WORD_WIDTH{1'b0}};
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            cpu_ack_q    <= 1'b0;
            cpu_err_q    <= 1'b0;
            cpu_rdata_q  <= {WORD_WIDTH{1'b0}};
            dma_ack_q    <= 1'b0;
            dma_err_q    <= 1'b0;
            dma_rdata_q  <= {WORD_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            err_q        <= err_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_err_q    <= cpu_err_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_ack_q    <= dma_ack_d;
            dma_err_q    <= dma_err_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    // addr_q/wdata_q only change on a grant, so they hold between accesses.
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wr    = (state_q == BUSY) & we_q & ~err_q;

    assign cpu_ack   = cpu_ack_q;
    assign cpu_err   = cpu_err_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_ack   = dma_ack_q;
    assign dma_err   = dma_err_q;
    assign dma_rdata = dma_rdata_q;

`ifdef DATAMEM_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] cpu_cnt_q, cpu_cnt_d;
    logic [CNT_WIDTH-1:0] dma_cnt_q, dma_cnt_d;

    // Saturating per-requester grant counts, error grants included.
    always_comb begin
        cpu_cnt_d = cpu_cnt_q;
        dma_cnt_d = dma_cnt_q;
        if ((state_q == IDLE) && gnt_s[0] && (cpu_cnt_q != {CNT_WIDTH{1'b1}})) begin
            cpu_cnt_d = cpu_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cpu_cnt_d = cpu_cnt_q;
        end
        if ((state_q == IDLE) && gnt_s[1] && (dma_cnt_q != {CNT_WIDTH{1'b1}})) begin
            dma_cnt_d = dma_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            dma_cnt_d = dma_cnt_q;
        end
    end

    // Grant counter registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cpu_cnt_q <= {CNT_WIDTH{1'b0}};
            dma_cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            cpu_cnt_q <= cpu_cnt_d;
            dma_cnt_q <= dma_cnt_d;
        end
    end

    assign cpu_grants = cpu_cnt_q;
    assign dma_grants = dma_cnt_q;
`else
    assign cpu_grants = {CNT_WIDTH{1'b0}};
    assign dma_grants = {CNT_WIDTH{1'b0}};
`endif

endmodule : datamem_arbiter

// File: tb/tb_datamem_arbiter.sv
// Directed, table-driven bench for datamem_arbiter with a byte-wide big-endian memory model.
module tb_datamem_arbiter;

    logic        clk;
    logic        nrst;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_ack, cpu_err, dma_ack, dma_err;
    logic [31:0] cpu_rdata, dma_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wr;
    logic [3:0]  cpu_grants, dma_grants;

    logic [7:0]  mem [0:1023] = '{default: 8'h00};
    logic [9:0]  idx;
    int          wr_cnt   = 0;
    int          both_cnt = 0;
    int          checks   = 0;
    int          errors   = 0;
    logic [31:0] prev_cpu_rd, prev_dma_rd;

    typedef struct {
        logic        is_dma;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [12];

    datamem_arbiter #(.WORD_WIDTH(32), .MEM_DEPTH(1024), .CNT_WIDTH(4)) dut (
        .clk(clk), .nrst(nrst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_err(dma_err), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cpu_grants(cpu_grants), .dma_grants(dma_grants)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational big-endian read, clocked write.
    always_comb begin
        idx       = mem_addr[9:0];
        mem_rdata = {mem[idx], mem[idx + 10'd1], mem[idx + 10'd2], mem[idx + 10'd3]};
    end

    always @(posedge clk) begin
        if (mem_wr) begin
            mem[idx]         <= mem_wdata[31:24];
            mem[idx + 10'd1] <= mem_wdata[23:16];
            mem[idx + 10'd2] <= mem_wdata[15:8];
            mem[idx + 10'd3] <= mem_wdata[7:0];
        end
    end

    always @(negedge clk) begin
        if (mem_wr) wr_cnt <= wr_cnt + 1;
        if (cpu_ack && dma_ack) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int          cyc;
        int          wr0;
        logic        got;
        logic [31:0] exp_rd;
        logic [31:0] act_rd;
        wr0 = wr_cnt;
        @(posedge clk); #1;
        if (v.is_dma) begin
            dma_req = 1'b1; dma_we = v.we; dma_addr = v.addr; dma_wdata = v.wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        end
        cyc = 0;
        got = 1'b0;
        while (cyc < 10 && !got) begin
            @(posedge clk); #1;
            cyc++;
            got = v.is_dma ? dma_ack : cpu_ack;
        end
        chk($sformatf("vec%0d_latency", k), 32'(cyc), 32'd2);
        chk($sformatf("vec%0d_err", k), {31'd0, (v.is_dma ? dma_err : cpu_err)}, {31'd0, v.exp_err});
        chk($sformatf("vec%0d_other_ack", k), {31'd0, (v.is_dma ? cpu_ack : dma_ack)}, 32'd0);
        chk($sformatf("vec%0d_memwr_count", k), 32'(wr_cnt - wr0),
            (v.we && !v.exp_err) ? 32'd1 : 32'd0);
        if (v.exp_err)  exp_rd = 32'd0;
        else if (!v.we) exp_rd = v.exp_rdata;
        else            exp_rd = v.is_dma ? prev_dma_rd : prev_cpu_rd;
        act_rd = v.is_dma ? dma_rdata : cpu_rdata;
        chk($sformatf("vec%0d_rdata", k), act_rd, exp_rd);
        if (v.is_dma) prev_dma_rd = exp_rd;
        else          prev_cpu_rd = exp_rd;
        cpu_req = 1'b0;
        dma_req = 1'b0;
    endtask

    initial begin
        int          n;
        int          ord [4];
        int          tim [4];
        logic [31:0] exp_cnt;
        logic [31:0] exp_dcnt;

        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 1'b1, 32'h0000_0020, 32'hA5A5_5A5A, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 1'b1, 32'h0000_0022, 32'hFFFF_FFFF, 1'b1, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'hA5A5_5A5A};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_03FC, 32'h1122_3344, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'h1122_3344};
        vecs[7]  = '{1'b0, 1'b0, 32'h0000_0400, 32'h0,         1'b1, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'h1122_3344};
        vecs[10] = '{1'b1, 1'b1, 32'h0000_0401, 32'h5555_5555, 1'b1, 32'h0};
        vecs[11] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};

        nrst = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'd0; dma_wdata = 32'd0;
        prev_cpu_rd = 32'd0;
        prev_dma_rd = 32'd0;
        #8;
        chk("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        chk("rst_dma_ack", {31'd0, dma_ack}, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        #4 nrst = 1'b1;

        for (int k = 0; k < 12; k++) begin
            run_vec(vecs[k], k);
            if (k == 0) chk("bytes_0x10", {mem[16], mem[17], mem[18], mem[19]}, 32'hDEAD_BEEF);
            if (k == 3) chk("bytes_0x20", {mem[32], mem[33], mem[34], mem[35]}, 32'hA5A5_5A5A);
        end

        // Reset in the middle of a write: no write, no ack, no rdata change.
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        chk("rst_mid_memwr_busy", {31'd0, mem_wr}, 32'd1);
        nrst = 1'b0;
        #1;
        chk("rst_mid_memwr_drop", {31'd0, mem_wr}, 32'd0);
        cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mid_no_ack", {31'd0, cpu_ack}, 32'd0);
        nrst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_no_ack2", {31'd0, cpu_ack}, 32'd0);
        chk("rst_mid_bytes_0x40", {mem[64], mem[65], mem[66], mem[67]}, 32'd0);
        chk("rst_mid_rdata", cpu_rdata, 32'd0);

        // Contention: both held from the same edge; first tie after reset goes to CPU.
        cpu_we = 1'b0; cpu_addr = 32'h10;
        dma_we = 1'b0; dma_addr = 32'h20;
        @(posedge clk); #1;
        cpu_req = 1'b1;
        dma_req = 1'b1;
        n = 0;
        for (int c = 1; c <= 16 && n < 4; c++) begin
            @(posedge clk); #1;
            if (cpu_ack) begin
                ord[n] = 0; tim[n] = c; n++;
                chk("cont_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
            end else if (dma_ack) begin
                ord[n] = 1; tim[n] = c; n++;
                chk("cont_dma_rdata", dma_rdata, 32'hA5A5_5A5A);
            end
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        chk("cont_ack_count", 32'(n), 32'd4);
        if (n == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("cont_order%0d", i), 32'(ord[i]), 32'(i % 2));
            end
            chk("cont_first_ack", 32'(tim[0]), 32'd2);
            for (int i = 1; i < 4; i++) begin
                chk($sformatf("cont_spacing%0d", i), 32'(tim[i] - tim[i-1]), 32'd3);
            end
        end
        chk("no_double_ack", 32'(both_cnt), 32'd0);

        // Saturating grant counters: 2 CPU grants above plus 20 more.
        for (int i = 0; i < 20; i++) begin
            run_vec(vecs[11], 100 + i);
        end
`ifdef DATAMEM_ARB_STATS_EN
        exp_cnt  = 32'd15;
        exp_dcnt = 32'd2;
`else
        exp_cnt  = 32'd0;
        exp_dcnt = 32'd0;
`endif
        chk("cpu_grants", {28'd0, cpu_grants}, exp_cnt);
        chk("dma_grants", {28'd0, dma_grants}, exp_dcnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_datamem_arbiter
